dmem_rr_arbiter: RTL
====================

// Module: dmem_rr_arbiter
// PURPOSE
//  Shares one data memory (8-bit address, 64-bit data, synchronous read) between
//  NPORTS processor nodes of the CMP. Each cycle it grants at most one request
//  using round-robin arbitration, drives the shared dmem port, and stalls the
//  losing nodes. It returns read data one cycle later, tagged to the node that
//  was granted. A node may lock the memory for a read-modify-write sequence.
// PARAMETERS
//  NPORTS    4    number of requesting nodes (2..8)
//  AW        8    memory address width
//  DW        64   memory data width
//  MAX_LOCK  16   maximum consecutive cycles one port may hold a lock
// PORTS
//  clk        in   1          system clock, posedge
//  reset      in   1          asynchronous, active-high
//  req_en     in   NPORTS     per-node access request (node memEn)
//  req_wr     in   NPORTS     per-node write enable (node memWrEn)
//  req_lock   in   NPORTS     per-node lock request; keeps the grant across cycles
//  req_addr   in   NPORTS*AW  packed addresses; node i = [i*AW +: AW]
//  req_wdata  in   NPORTS*DW  packed write data; node i = [i*DW +: DW]
//  gnt        out  NPORTS     one-hot grant for this cycle
//  stall      out  NPORTS     req_en & ~gnt; node holds its request
//  rd_valid   out  NPORTS     one-hot; read data for node i is on rd_data
//  rd_data    out  DW         read data, valid for the cycle after the granted read
//  mem_en     out  1          shared dmem enable
//  mem_wr_en  out  1          shared dmem write enable
//  mem_addr   out  AW         shared dmem address
//  mem_wdata  out  DW         shared dmem write data
//  mem_rdata  in   DW         shared dmem read data (1-cycle latency)
// BEHAVIOUR
//  - Reset values: state=IDLE, prio_ptr=0, lock_owner=0, lock_cnt=0, rd_valid=0.
//    gnt, stall, mem_en and mem_wr_en evaluate to 0 while reset is high.
//  - The grant is combinational from the registered state. In IDLE the winner is the
//    first req_en[i] searching from prio_ptr upward modulo NPORTS. At most one gnt bit
//    is ever high.
//  - Memory mux: mem_en=|gnt, mem_wr_en=req_wr[winner]&mem_en. mem_addr and mem_wdata
//    carry the winner's fields; they are 0 when no grant.
//  - After a granted access prio_ptr <= winner+1 (wraps NPORTS-1 -> 0). An idle cycle
//    leaves prio_ptr unchanged.
//  - Read return: a granted read sets rd_valid[winner] for exactly the next cycle and
//    rd_data=mem_rdata. A write produces no rd_valid.
//  - FSM:
//    IDLE   -> LOCKED when a grant is issued with req_lock[winner]=1; lock_owner <=
//              winner, lock_cnt <= 1.
//    LOCKED -> only lock_owner is eligible for gnt, and only while its req_en=1. All
//              other requesters are stalled. lock_cnt increments each cycle.
//    LOCKED -> IDLE when req_lock[owner]=0, or when lock_cnt reaches MAX_LOCK (forced
//              release). On exit prio_ptr <= owner+1.
//  - On a forced release the owner cannot relock until it has dropped req_lock for at
//    least one cycle (relock_block flag).
//  - Simultaneous requests: the fairness guarantee is that a requester waits at most
//    NPORTS-1 grants, plus any active lock of MAX_LOCK cycles or fewer.
//  - Asserting reset mid-access aborts the access: pending rd_valid clears and the lock
//    is dropped. The memory contents are not touched by the arbiter.
// STRUCTURE
//  - Shared package dmem_arb_pkg holds the state enum (IDLE, LOCKED), the default
//    AW/DW values, and the function rr_pick(req, ptr) returning a one-hot grant.
//  - One sub-module, rr_pick_nports: the combinational rotate / priority-encode /
//    rotate-back. The top level holds the FSM, counters and the read-return register.
// TESTING
//  1. Reset, no requests: gnt=0, mem_en=0, rd_valid=0 for 10 cycles; prio_ptr stays 0.
//  2. All 4 ports assert req_en with reads of addresses 0x10..0x13 held for 4 cycles:
//     grants go 0,1,2,3. rd_valid arrives one cycle after each grant with
//     rd_data=MEM[0x10..0x13], and stall matches the non-granted ports.
//  3. Port 2 writes 0xDEADBEEF_00000001 to 0x05. Next cycle port 0 reads 0x05: rd_data
//     equals the written value and no rd_valid follows the write.
//  4. Port 1 asserts req_lock with reads for 3 cycles while ports 0 and 3 request:
//     gnt=0010 for 3 cycles and ports 0 and 3 are stalled. After the lock drops the
//     next grant is port 3.
//  5. Port 0 holds req_lock with MAX_LOCK=16: the lock is force-released at cycle 16,
//     port 1 is granted next, and port 0 is not relocked until req_lock toggles.
//  6. Reset asserted the cycle after a granted read in LOCKED state: rd_valid is 0
//     immediately, state=IDLE, prio_ptr=0 after reset is released.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOCKED)
//   DEF_AW      : default memory address width
//   DEF_DW      : default memory data width
//   rr_pick     : round-robin pick of up to 8 requesters, returns one-hot grant
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 64;

  // Scan requesters starting at ptr and wrapping modulo n; the first one found
  // wins. Only the low n bits of req are considered.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int n);
    logic [7:0] g;
    logic       found;
    int         idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_pick_nports.sv
// Combinational round-robin picker.
//   req    in  NPORTS  request vector
//   ptr    in  PW      highest-priority port this cycle (must be < NPORTS)
//   gnt    out NPORTS  one-hot grant, zero when nothing is requested
//   winner out PW      index of the granted port (meaningless when gnt is zero)
module rr_pick_nports import dmem_arb_pkg::*; #(
  parameter int NPORTS = 4,
  parameter int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NPORTS-1:0] gnt,
  output logic [PW-1:0]     winner
);

  logic [2*NPORTS-1:0] dbl;
  logic [NPORTS-1:0]   rot;
  logic [PW-1:0]       pos;
  logic [PW:0]         sum;
  logic                any;

  // Rotate the requests so ptr sits at bit 0, take the lowest set bit, then
  // add ptr back (mod NPORTS) to recover the real port index.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NPORTS-1:0];
    pos = '0;
    any = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = PW'(i);
        any = 1'b1;
      end
    end
    sum = {1'b0, pos} + {1'b0, ptr};
    if (sum >= (PW+1)'(NPORTS)) begin
      sum = sum - (PW+1)'(NPORTS);
    end
    winner = sum[PW-1:0];
    gnt    = any ? (NPORTS'(1) << winner) : '0;
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory among NPORTS
// nodes, with an optional per-node lock for read-modify-write sequences.
//   clk, reset                 clock (posedge) and async active-high reset
//   req_en/req_wr/req_lock     per-node request, write enable, lock request
//   req_addr/req_wdata         packed per-node address and write data
//   gnt/stall                  one-hot grant and per-node stall
//   rd_valid/rd_data           read return, one cycle after a granted read
//   mem_en/mem_wr_en/mem_addr/mem_wdata/mem_rdata   shared memory port
module dmem_rr_arbiter import dmem_arb_pkg::*; #(
  parameter int NPORTS   = 4,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_LOCK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req_en,
  input  logic [NPORTS-1:0]    req_wr,
  input  logic [NPORTS-1:0]    req_lock,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*DW-1:0] req_wdata,
  output logic [NPORTS-1:0]    gnt,
  output logic [NPORTS-1:0]    stall,
  output logic [NPORTS-1:0]    rd_valid,
  output logic [DW-1:0]        rd_data,
  output logic                 mem_en,
  output logic                 mem_wr_en,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t        state, state_d;
  logic [PW-1:0]     prio_ptr;
  logic [PW-1:0]     lock_owner;
  logic [CW-1:0]     lock_cnt;
  logic              relock_block;
  logic [NPORTS-1:0] rd_valid_q;

  logic [NPORTS-1:0] idle_gnt;
  logic [PW-1:0]     idle_winner;
  logic [PW-1:0]     winner;
  logic              granted;
  logic              lock_hit;
  logic              release_lock;
  logic              forced_release;
  logic              enter_lock;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    if (int'(p) == NPORTS - 1) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  rr_pick_nports #(.NPORTS(NPORTS), .PW(PW)) u_pick (
    .req    (req_en),
    .ptr    (prio_ptr),
    .gnt    (idle_gnt),
    .winner (idle_winner)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic. A lock ends either voluntarily or when the owner has held
  // it for MAX_LOCK cycles (the entry cycle counts as the first). A port that
  // was forced out may not re-enter the lock until it drops req_lock once.
  always_comb begin
    granted        = |gnt;
    lock_hit       = (lock_cnt >= CW'(MAX_LOCK - 1));
    release_lock   = (state == LOCKED) && (!req_lock[lock_owner] || lock_hit);
    forced_release = (state == LOCKED) && req_lock[lock_owner] && lock_hit;
    enter_lock     = (state == IDLE) && granted && req_lock[winner] &&
                     !(relock_block && (winner == lock_owner));
    state_d = state;
    case (state)
      IDLE:    if (enter_lock)   state_d = LOCKED;
      LOCKED:  if (release_lock) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and memory-port mux. While locked only the owner can win, and only
  // when it is actually requesting. Everything is forced quiet during reset.
  always_comb begin
    gnt    = '0;
    winner = idle_winner;
    if (state == IDLE) begin
      gnt = idle_gnt;
    end else begin
      winner = lock_owner;
      if (req_en[lock_owner]) begin
        gnt[lock_owner] = 1'b1;
      end
    end
    if (reset) begin
      gnt = '0;
    end
    stall     = reset ? '0 : (req_en & ~gnt);
    mem_en    = |gnt;
    mem_wr_en = req_wr[winner] & mem_en;
    mem_addr  = mem_en ? req_addr[int'(winner)*AW +: AW] : '0;
    mem_wdata = mem_en ? req_wdata[int'(winner)*DW +: DW] : '0;
    rd_valid  = rd_valid_q;
    rd_data   = mem_rdata;
  end

  // Priority pointer, lock bookkeeping and the read-return tag. On lock exit
  // the pointer moves past the owner so the other nodes get their turn next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_ptr     <= '0;
      lock_owner   <= '0;
      lock_cnt     <= '0;
      relock_block <= 1'b0;
      rd_valid_q   <= '0;
    end else begin
      rd_valid_q <= (granted && !mem_wr_en) ? gnt : '0;
      if (release_lock) begin
        prio_ptr <= next_port(lock_owner);
      end else if (granted) begin
        prio_ptr <= next_port(winner);
      end
      if (enter_lock) begin
        lock_owner <= winner;
        lock_cnt   <= CW'(1);
      end else if (release_lock) begin
        lock_cnt <= '0;
      end else if (state == LOCKED) begin
        lock_cnt <= lock_cnt + CW'(1);
      end
      if (forced_release) begin
        relock_block <= 1'b1;
      end else if (enter_lock || !req_lock[lock_owner]) begin
        relock_block <= 1'b0;
      end
    end
  end

endmodule
